keypad_entry: RTL and testbench

- Scans a 4x4 matrix keypad, debounces each key, and assembles up to 4 BCD digits into a 16-bit operand for the ALU operand registers (reg1/reg2 path).
- It is the input-side counterpart of the 7-segment display driver. Its `digits` output can feed the display directly for live echo.
- Single clock domain; key actions are registered single-cycle pulses.

---
 rtl/keypad_pkg.sv | 32 +++
 rtl/kp_debounce.sv | 32 +++
 rtl/keypad_entry.sv | 139 +++++++++++++
 tb/tb_keypad_entry.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad entry block: key codes, FSM encoding, helpers.
package keypad_pkg;

    localparam int unsigned MAX_DIGITS          = 4;
    localparam int unsigned SCAN_DIV_DEF        = 4;
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 8;

    localparam logic [3:0] KEY_ENTER = 4'hA;
    localparam logic [3:0] KEY_CLEAR = 4'hB;
    localparam logic [3:0] KEY_BKSP  = 4'hC;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } kp_state_t;

    // Index of the lowest set bit; also turns a one-hot column into its index.
    function automatic logic [1:0] lowest_idx(input logic [3:0] v);
        if (v[0])      return 2'd0;
        else if (v[1]) return 2'd1;
        else if (v[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    // Rotate the column drive left by one position.
    function automatic logic [3:0] rotl(input logic [3:0] v);
        return {v[2:0], v[3]};
    endfunction

endpackage

// File: rtl/kp_debounce.sv
// Stable-level counter shared by the press and release phases of the keypad FSM.
module kp_debounce #(
    parameter int unsigned CYCLES = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    input  logic lvl,
    output logic stable_c
);

    localparam int unsigned CNT_W = $clog2(CYCLES + 1);

    logic [CNT_W-1:0] cnt;

    // Load starts a press at one sample; otherwise count consecutive lvl=1 clocks, saturating.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CNT_W'(1);
        end else if (!en || !lvl) begin
            cnt <= '0;
        end else if (cnt != CNT_W'(CYCLES)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign stable_c = (cnt == CNT_W'(CYCLES));

endmodule

// File: rtl/keypad_entry.sv
// 4x4 keypad scanner with debounce and a 4-digit BCD entry buffer.
// Optional macro KEYPAD_AUTO_ENTER_EN: the fourth digit implies an ENTER on the same edge.
module keypad_entry
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV        = SCAN_DIV_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  row,
    output logic [3:0]  col,
    output logic [15:0] digits,
    output logic [2:0]  ndig,
    output logic        key_strobe,
    output logic [3:0]  key_code,
    output logic [15:0] operand,
    output logic        operand_valid
);

    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    kp_state_t        state;
    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       row_idx;
    logic [1:0]       col_idx;
    logic [3:0]       code;
    logic             sample;
    logic             db_load;
    logic             db_en;
    logic             db_lvl;
    logic             db_stable;

    assign code    = {row_idx, col_idx};
    assign sample  = (div_cnt == DIV_W'(SCAN_DIV - 1));
    assign db_load = (state == ST_SCAN) && sample && (row != 4'h0);
    assign db_en   = (state == ST_DEBOUNCE) || (state == ST_RELEASE);
    // Press phase counts closed samples, release phase counts open ones.
    assign db_lvl  = (state == ST_RELEASE) ? ~row[row_idx] : row[row_idx];

    kp_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_debounce (
        .clk      (clk),
        .rst      (rst),
        .load     (db_load),
        .en       (db_en),
        .lvl      (db_lvl),
        .stable_c (db_stable)
    );

    // Scan rotation, key FSM and digit buffer, all registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_SCAN;
            div_cnt       <= '0;
            col           <= 4'b0001;
            row_idx       <= 2'd0;
            col_idx       <= 2'd0;
            digits        <= 16'h0000;
            ndig          <= 3'd0;
            key_strobe    <= 1'b0;
            key_code      <= 4'h0;
            operand       <= 16'h0000;
            operand_valid <= 1'b0;
        end else begin
            key_strobe    <= 1'b0;
            operand_valid <= 1'b0;
            case (state)
                ST_SCAN: begin
                    if (sample) begin
                        div_cnt <= '0;
                        if (row != 4'h0) begin
                            row_idx <= lowest_idx(row);
                            col_idx <= lowest_idx(col);
                            state   <= ST_DEBOUNCE;
                        end else begin
                            col <= rotl(col);
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                ST_DEBOUNCE: begin
                    if (db_stable) begin
                        state <= ST_HELD;
                    end else if (!row[row_idx]) begin
                        state   <= ST_SCAN;
                        col     <= rotl(col);
                        div_cnt <= '0;
                    end
                end
                ST_HELD: begin
                    key_strobe <= 1'b1;
                    key_code   <= code;
                    state      <= ST_RELEASE;
                    if (code <= 4'd9) begin
                        if (ndig < 3'(MAX_DIGITS)) begin
`ifdef KEYPAD_AUTO_ENTER_EN
                            if (ndig == 3'(MAX_DIGITS - 1)) begin
                                operand       <= {digits[11:0], code};
                                operand_valid <= 1'b1;
                                digits        <= 16'h0000;
                                ndig          <= 3'd0;
                            end else begin
                                digits <= {digits[11:0], code};
                                ndig   <= ndig + 3'd1;
                            end
`else
                            digits <= {digits[11:0], code};
                            ndig   <= ndig + 3'd1;
`endif
                        end
                    end else if (code == KEY_ENTER) begin
                        operand       <= digits;
                        operand_valid <= 1'b1;
                        digits        <= 16'h0000;
                        ndig          <= 3'd0;
                    end else if (code == KEY_CLEAR) begin
                        digits <= 16'h0000;
                        ndig   <= 3'd0;
                    end else if (code == KEY_BKSP) begin
                        if (ndig != 3'd0) begin
                            digits <= {4'h0, digits[15:4]};
                            ndig   <= ndig - 3'd1;
                        end
                    end
                end
                ST_RELEASE: begin
                    if (db_stable) begin
                        state   <= ST_SCAN;
                        col     <= rotl(col);
                        div_cnt <= '0;
                    end
                end
                default: state <= ST_SCAN;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_entry.sv
// Bench for keypad_entry: directed table, multi-cycle corner cases, random presses vs. a queue model.
module tb_keypad_entry;

    localparam int unsigned SCAN_DIV = 4;
    localparam int unsigned DEB      = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [15:0] digits;
    logic [2:0]  ndig;
    logic        key_strobe;
    logic [3:0]  key_code;
    logic [15:0] operand;
    logic        operand_valid;

    logic        key_down;
    logic [3:0]  key_sel;

    int n_vec = 0;
    int n_err = 0;
    int strobes = 0;
    int opvs = 0;
    logic prev_strobe = 1'b0;

    keypad_entry #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk           (clk),
        .rst           (rst),
        .row           (row),
        .col           (col),
        .digits        (digits),
        .ndig          (ndig),
        .key_strobe    (key_strobe),
        .key_code      (key_code),
        .operand       (operand),
        .operand_valid (operand_valid)
    );

    always #5 clk = ~clk;

    // Keypad matrix: the selected key closes its row while its column is driven.
    assign row = (key_down && col[key_sel[1:0]]) ? (4'b0001 << key_sel[3:2]) : 4'b0000;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Pulse monitor: count pulses, no back-to-back strobes, operand_valid only with a strobe.
    always @(negedge clk) begin
        if (key_strobe) begin
            strobes++;
            n_vec++;
            if (prev_strobe) begin
                n_err++;
                $display("FAIL strobe_spacing: got consecutive strobes expected isolated pulse");
            end
        end
        if (operand_valid) begin
            opvs++;
            n_vec++;
            if (!key_strobe) begin
                n_err++;
                $display("FAIL opv_alone: got operand_valid=1 key_strobe=0 expected both");
            end
        end
        prev_strobe = key_strobe;
    end

    typedef struct {
        logic [3:0]  code;
        logic [15:0] digits;
        logic [2:0]  ndig;
        logic [15:0] operand;
        int          opv;
    } vec_t;

    vec_t tbl[19];

`ifdef KEYPAD_AUTO_ENTER_EN
    localparam logic [15:0] OP_MID = 16'h5555;
`else
    localparam logic [15:0] OP_MID = 16'h1274;
`endif

    // Reference model: entry buffer as a queue of digits.
    int          mq[$];
    logic [15:0] m_op;
    int          m_opv;

    function automatic logic [15:0] pack_q();
        logic [15:0] v = 16'h0;
        foreach (mq[i]) v = 16'(v * 16 + mq[i]);
        return v;
    endfunction

    task automatic model_key(input int k);
        m_opv = 0;
        if (k <= 9) begin
            if (mq.size() < 4) begin
                mq.push_back(k);
`ifdef KEYPAD_AUTO_ENTER_EN
                if (mq.size() == 4) begin
                    m_op  = pack_q();
                    m_opv = 1;
                    mq.delete();
                end
`endif
            end
        end else if (k == 10) begin
            m_op  = pack_q();
            m_opv = 1;
            mq.delete();
        end else if (k == 11) begin
            mq.delete();
        end else if (k == 12) begin
            if (mq.size() > 0) void'(mq.pop_back());
        end
    endtask

    task automatic press(input logic [3:0] code, input int hold, input int rel);
        @(negedge clk);
        key_sel  = code;
        key_down = 1'b1;
        repeat (hold) @(negedge clk);
        key_down = 1'b0;
        repeat (rel) @(negedge clk);
    endtask

    task automatic press_check(input string nm, input logic [3:0] code, input int hold, input int rel,
                               input logic [15:0] e_dig, input logic [2:0] e_nd,
                               input logic [15:0] e_op, input int e_opv);
        int s0 = strobes;
        int o0 = opvs;
        press(code, hold, rel);
        chk({nm, ".strobes"}, 16'(strobes - s0), 16'd1);
        chk({nm, ".key_code"}, 16'(key_code), 16'(code));
        chk({nm, ".digits"}, digits, e_dig);
        chk({nm, ".ndig"}, 16'(ndig), 16'(e_nd));
        chk({nm, ".operand"}, operand, e_op);
        chk({nm, ".opv"}, 16'(opvs - o0), 16'(e_opv));
    endtask

    initial begin
        int s0;
        int lat;
        logic [3:0] c0;
        bit found;

        tbl[0]  = '{4'h1, 16'h0001, 3'd1, 16'h0000, 0};
        tbl[1]  = '{4'h2, 16'h0012, 3'd2, 16'h0000, 0};
        tbl[2]  = '{4'h7, 16'h0127, 3'd3, 16'h0000, 0};
        tbl[3]  = '{4'h4, 16'h1274, 3'd4, 16'h0000, 0};
        tbl[4]  = '{4'hA, 16'h0000, 3'd0, 16'h1274, 1};
        tbl[5]  = '{4'h5, 16'h0005, 3'd1, 16'h1274, 0};
        tbl[6]  = '{4'h5, 16'h0055, 3'd2, 16'h1274, 0};
        tbl[7]  = '{4'h5, 16'h0555, 3'd3, 16'h1274, 0};
`ifdef KEYPAD_AUTO_ENTER_EN
        tbl[8]  = '{4'h5, 16'h0000, 3'd0, 16'h5555, 1};
        tbl[9]  = '{4'h9, 16'h0009, 3'd1, 16'h5555, 0};
`else
        tbl[8]  = '{4'h5, 16'h5555, 3'd4, 16'h1274, 0};
        tbl[9]  = '{4'h9, 16'h5555, 3'd4, 16'h1274, 0};
`endif
        tbl[10] = '{4'hB, 16'h0000, 3'd0, OP_MID, 0};
        tbl[11] = '{4'h3, 16'h0003, 3'd1, OP_MID, 0};
        tbl[12] = '{4'h8, 16'h0038, 3'd2, OP_MID, 0};
        tbl[13] = '{4'hC, 16'h0003, 3'd1, OP_MID, 0};
        tbl[14] = '{4'hC, 16'h0000, 3'd0, OP_MID, 0};
        tbl[15] = '{4'hC, 16'h0000, 3'd0, OP_MID, 0};
        tbl[16] = '{4'hB, 16'h0000, 3'd0, OP_MID, 0};
        tbl[17] = '{4'hD, 16'h0000, 3'd0, OP_MID, 0};
        tbl[18] = '{4'hA, 16'h0000, 3'd0, 16'h0000, 1};

        key_down = 1'b0;
        key_sel  = 4'h0;
        rst      = 1'b1;
        repeat (3) @(negedge clk);

        // Reset values
        chk("rst.col", 16'(col), 16'h0001);
        chk("rst.digits", digits, 16'h0000);
        chk("rst.ndig", 16'(ndig), 16'h0000);
        chk("rst.key_code", 16'(key_code), 16'h0000);
        chk("rst.operand", operand, 16'h0000);
        chk("rst.pulses", 16'({key_strobe, operand_valid}), 16'h0000);
        rst = 1'b0;

        // Directed table
        for (int i = 0; i < 19; i++) begin
            press_check($sformatf("tbl%0d", i), tbl[i].code, 40, 20,
                        tbl[i].digits, tbl[i].ndig, tbl[i].operand, tbl[i].opv);
        end

        // Bouncing key 6 never produces a strobe; scanning then continues.
        s0 = strobes;
        @(negedge clk);
        key_sel  = 4'h6;
        key_down = 1'b1;
        for (int i = 0; i < 10; i++) begin
            repeat (3) @(negedge clk);
            key_down = ~key_down;
        end
        key_down = 1'b0;
        repeat (20) @(negedge clk);
        chk("bounce.strobes", 16'(strobes - s0), 16'd0);
        c0 = col;
        repeat (SCAN_DIV) @(negedge clk);
        chk("bounce.col_rotates", 16'(col), 16'({c0[2:0], c0[3]}));

        // Latency from a known scan phase right after reset: sample at edge SCAN_DIV.
        rst = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        key_sel  = 4'h4;
        key_down = 1'b1;
        s0  = strobes;
        lat = -1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk);
            #1;
            if (key_strobe && lat < 0) lat = cyc;
        end
        chk("hold.latency", 16'(lat), 16'(SCAN_DIV + DEB + 1));
        repeat (160) @(negedge clk);
        key_down = 1'b0;
        repeat (20) @(negedge clk);
        chk("hold.strobes", 16'(strobes - s0), 16'd1);
        chk("hold.digits", digits, 16'h0004);
        chk("hold.ndig", 16'(ndig), 16'd1);

        // Second press of 4, reset asserted when the press counter reaches 5.
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (!col[0]) found = 1'b1;
        end
        key_down = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge clk);
            #1;
            if (row != 4'h0) found = 1'b1;
        end
        chk("rstmid.row_seen", 16'(found), 16'd1);
        s0 = strobes;
        repeat (8) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rstmid.col", 16'(col), 16'h0001);
        chk("rstmid.digits", digits, 16'h0000);
        chk("rstmid.ndig", 16'(ndig), 16'd0);
        chk("rstmid.key_code", 16'(key_code), 16'h0000);
        chk("rstmid.pulses", 16'({key_strobe, operand_valid}), 16'h0000);
        @(negedge clk);
        key_down = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("rstmid.strobes", 16'(strobes - s0), 16'd0);

        // Random clean presses against the queue model (starts empty after the reset above).
        mq.delete();
        m_op = 16'h0000;
        for (int i = 0; i < 40; i++) begin
            logic [3:0] k;
            k = 4'($urandom_range(0, 15));
            model_key(int'(k));
            press_check($sformatf("rnd%0d_k%h", i, k), k,
                        30 + int'($urandom_range(0, 19)), 12 + int'($urandom_range(0, 9)),
                        pack_q(), 3'(mq.size()), m_op, m_opv);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
